// File: rtl/arisco_pkg.sv
// Shared constants and fetch FSM encoding for the arisco core.
package arisco_pkg;

   localparam int          ILEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   function automatic logic word_aligned(input logic [ILEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches one word per req/ack and presents it on valid/ready.
// Latency: instr_valid rises 1 cycle after mem_ack; next request issues the cycle after acceptance.
// Backpressure: instr held stable until instr_ready; no new fetch while an instruction is pending.
module instruction_fetch
   import arisco_pkg::*;
#(
   parameter logic [ILEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst,
   output logic            mem_req,
   output logic [ILEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [ILEN-1:0] mem_rdata,
   output logic [ILEN-1:0] instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [ILEN-1:0] pc,
   input  logic            redirect_valid,
   input  logic [ILEN-1:0] redirect_pc,
   output logic            fault,
   output logic [31:0]     fetch_count
);

   localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   fetch_state_t    state_q, state_d;
   logic [ILEN-1:0] pc_d, instr_d;
   logic            req_d, vld_d, fault_d;
   logic [31:0]     cnt_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;

   assign mem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_REQ;
         pc          <= RESET_PC;
         mem_req     <= 1'b0;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
         fetch_count <= 32'd0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc          <= pc_d;
         mem_req     <= req_d;
         instr       <= instr_d;
         instr_valid <= vld_d;
         fault       <= fault_d;
         fetch_count <= cnt_d;
         tcnt_q      <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      req_d   = mem_req;
      instr_d = instr;
      vld_d   = instr_valid;
      fault_d = fault;
      cnt_d   = fetch_count;
      tcnt_d  = tcnt_q;

      case (state_q)
         ST_REQ: begin
            req_d = 1'b1;
            // Redirect outranks a same-cycle ack; the acked word is dropped.
            if (redirect_valid) begin
               if (word_aligned(redirect_pc)) begin
                  pc_d   = redirect_pc;
                  vld_d  = 1'b0;
                  tcnt_d = '0;
               end else begin
                  fault_d = 1'b1;
                  req_d   = 1'b0;
                  vld_d   = 1'b0;
                  state_d = ST_FAULT;
               end
            end else if (mem_ack) begin
               instr_d = mem_rdata;
               vld_d   = 1'b1;
               req_d   = 1'b0;
               tcnt_d  = '0;
               state_d = ST_HOLD;
            end else if (tcnt_q == TLAST) begin
               fault_d = 1'b1;
               req_d   = 1'b0;
               state_d = ST_FAULT;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end

         ST_HOLD: begin
            req_d = 1'b0;
            if (redirect_valid) begin
               vld_d = 1'b0;
               if (word_aligned(redirect_pc)) begin
                  pc_d    = redirect_pc;
                  tcnt_d  = '0;
                  req_d   = 1'b1;
                  state_d = ST_REQ;
               end else begin
                  fault_d = 1'b1;
                  state_d = ST_FAULT;
               end
            end else if (instr_ready) begin
               pc_d    = pc + 32'd4;
               cnt_d   = fetch_count + 32'd1;
               vld_d   = 1'b0;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end

         default: begin
            req_d   = 1'b0;
            vld_d   = 1'b0;
            state_d = ST_FAULT;
         end
      endcase
   end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fault;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   instruction_fetch #(.RESET_PC(32'h0000_0100), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fault(fault), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic [31:0] rd, input logic rdy,
                        input logic rv, input logic [31:0] rpc);
      mem_ack        = ack;
      mem_rdata      = rd;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
   endfunction

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic        e_fault;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   // Model state for the randomized phase
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_vld, m_req;
   int          wait_c;

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      //          ack   rdata         rdy   rv    rpc            req   addr           vld   instr          flt   cnt
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h100,       1'b0, 32'h13,       1'b0, 0});
      vecs.push_back('{1'b1, 32'h00C00293, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100,       1'b1, 32'h00C00293, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h100,       1'b1, 32'h00C00293, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h100,       1'b1, 32'h00C00293, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h100,       1'b1, 32'h00C00293, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h100,       1'b1, 32'h00C00293, 1'b0, 0});
      vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h104,       1'b0, 32'h00C00293, 1'b0, 1});
      vecs.push_back('{1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0,        1'b0, 32'h104,       1'b1, 32'h11111111, 1'b0, 1});
      vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      1'b1, 32'h200,       1'b0, 32'h11111111, 1'b0, 1});
      vecs.push_back('{1'b1, 32'h22222222, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC,  1'b0, 32'h11111111, 1'b0, 1});
      vecs.push_back('{1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFC,  1'b1, 32'h33333333, 1'b0, 1});
      vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h0,         1'b0, 32'h33333333, 1'b0, 2});
      vecs.push_back('{1'b1, 32'h44444444, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h44444444, 1'b0, 2});
      vecs.push_back('{1'b1, 32'h55555555, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b1, 32'h44444444, 1'b0, 2});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h202,      1'b0, 32'h0,         1'b0, 32'h44444444, 1'b1, 2});
      vecs.push_back('{1'b1, 32'h66666666, 1'b1, 1'b1, 32'h300,      1'b0, 32'h0,         1'b0, 32'h44444444, 1'b1, 2});
      vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h44444444, 1'b1, 2});

      // Reset state, checked while rst is still held
      repeat (2) @(negedge clk);
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h100);
      chk("rst_pc", pc, 32'h100);
      chk("rst_vld", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_cnt", fetch_count, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
         @(negedge clk);
         chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
         chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].e_addr);
         chk($sformatf("v%0d_vld", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_vld});
         chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
         chk($sformatf("v%0d_fault", i), {31'b0, fault}, {31'b0, vecs[i].e_fault});
         chk($sformatf("v%0d_cnt", i), fetch_count, vecs[i].e_cnt);
      end

      // Timeout: four REQ cycles without ack raise the sticky fault
      do_reset();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("to_fault_c%0d", c), {31'b0, fault}, (c == 4) ? 32'd1 : 32'd0);
         chk($sformatf("to_req_c%0d", c), {31'b0, mem_req}, (c == 4) ? 32'd0 : 32'd1);
      end
      repeat (3) @(negedge clk);
      chk("to_sticky", {31'b0, fault}, 32'd1);
      do_reset();
      @(negedge clk);
      chk("to_clr_fault", {31'b0, fault}, 32'd0);
      chk("to_clr_addr", mem_addr, 32'h100);
      chk("to_clr_req", {31'b0, mem_req}, 32'd1);

      // Misaligned redirect while a request is outstanding
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0101);
      @(negedge clk);
      chk("mis_req_fault", {31'b0, fault}, 32'd1);
      chk("mis_req_pc", pc, 32'h100);
      chk("mis_req_req", {31'b0, mem_req}, 32'd0);

      // Randomized run against the transaction-level model
      do_reset();
      m_pc = 32'h100; m_instr = 32'h13; m_cnt = 0; m_vld = 1'b0;
      m_req = 1'b1;  // one edge with rst low has already been taken
      wait_c = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         chk("rnd_req", {31'b0, mem_req}, {31'b0, m_req});
         chk("rnd_addr", mem_addr, m_pc);
         chk("rnd_pc", pc, m_pc);
         chk("rnd_vld", {31'b0, instr_valid}, {31'b0, m_vld});
         if (m_vld) chk("rnd_instr", instr, m_instr);
         chk("rnd_cnt", fetch_count, m_cnt);
         chk("rnd_fault", {31'b0, fault}, 32'd0);

         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         instr_ready    = $urandom_range(0, 1) == 1;
         mem_ack        = mem_req && (wait_c >= 1 || $urandom_range(0, 1) == 1);
         mem_rdata      = mem_ack ? mem_word(mem_addr) : $urandom;

         if (redirect_valid) begin
            m_pc  = redirect_pc;
            m_vld = 1'b0;
         end else if (m_vld && instr_ready) begin
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 1;
            m_vld = 1'b0;
         end else if (!m_vld && mem_ack) begin
            m_instr = mem_word(m_pc);
            m_vld   = 1'b1;
         end
         m_req = !m_vld;

         if (redirect_valid || mem_ack) wait_c = 0;
         else if (mem_req) wait_c++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
